// File: rtl/sdram_pkg.sv
// Shared types for the two-port SDRAM burst arbiter: state encoding, latched grant payload.
package sdram_pkg;

    localparam int unsigned NUM_PORTS    = 2;
    localparam int unsigned GRANT_ADDR_W = 24;
    localparam int unsigned GRANT_LEN_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_GRANT = 2'd1,
        ST_RD_GRANT = 2'd2,
        ST_RELEASE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        KIND_RD = 1'b0,
        KIND_WR = 1'b1
    } burst_kind_e;

    typedef struct packed {
        logic                    port;
        burst_kind_e             kind;
        logic [GRANT_LEN_W-1:0]  len;
        logic [GRANT_ADDR_W-1:0] addr;
    } grant_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational port winner selection. SDRAM_ARB_RR_EN selects round-robin,
// otherwise port 0 has fixed priority and no last-granted input exists.
module sdram_arb_pick
    import sdram_pkg::*;
(
`ifdef SDRAM_ARB_RR_EN
    input  logic                 last,
`endif
    input  logic [NUM_PORTS-1:0] req,
    output logic                 valid,
    output logic                 winner
);

    assign valid = |req;

`ifdef SDRAM_ARB_RR_EN
    // On contention the port that did not win last time goes next.
    assign winner = (&req) ? ~last : req[1];
`else
    assign winner = req[1] & ~req[0];
`endif

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Two-port burst arbiter in front of a single SDRAM controller user interface.
// Build option SDRAM_ARB_RR_EN: round-robin between ports instead of port-0 priority.
module sdram_burst_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = GRANT_ADDR_W,
    parameter int unsigned MEM_DATA_WIDTH = 16,
    parameter int unsigned BUSRT_WIDTH    = GRANT_LEN_W
) (
    input  logic                        i_sys_clk,
    input  logic                        i_sys_rst,

    input  logic [1:0]                  i_wr_burst_req,
    input  logic [2*BUSRT_WIDTH-1:0]    i_wr_burst_len,
    input  logic [2*ADDR_WIDTH-1:0]     i_wr_burst_addr,
    output logic [1:0]                  o_wr_burst_data_req,
    input  logic [2*MEM_DATA_WIDTH-1:0] i_wr_burst_data,
    output logic [1:0]                  o_wr_burst_finish,

    input  logic [1:0]                  i_rd_burst_req,
    input  logic [2*BUSRT_WIDTH-1:0]    i_rd_burst_len,
    input  logic [2*ADDR_WIDTH-1:0]     i_rd_burst_addr,
    output logic [1:0]                  o_rd_burst_data_valid,
    output logic [MEM_DATA_WIDTH-1:0]   o_rd_burst_data,
    output logic [1:0]                  o_rd_burst_finish,

    output logic                        o_mem_wr_burst_req,
    output logic [BUSRT_WIDTH-1:0]      o_mem_wr_burst_len,
    output logic [ADDR_WIDTH-1:0]       o_mem_wr_burst_addr,
    input  logic                        i_mem_wr_burst_data_req,
    output logic [MEM_DATA_WIDTH-1:0]   o_mem_wr_burst_data,
    input  logic                        i_mem_wr_burst_finish,

    output logic                        o_mem_rd_burst_req,
    output logic [BUSRT_WIDTH-1:0]      o_mem_rd_burst_len,
    output logic [ADDR_WIDTH-1:0]       o_mem_rd_burst_addr,
    input  logic                        i_mem_rd_burst_data_valid,
    input  logic [MEM_DATA_WIDTH-1:0]   i_mem_rd_burst_data,
    input  logic                        i_mem_rd_burst_finish
);

    localparam int unsigned BW = BUSRT_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = MEM_DATA_WIDTH;

    arb_state_e           state_q, state_d;
    grant_t               grant_q, grant_d;
    logic                 mem_wr_req_q, mem_wr_req_d;
    logic                 mem_rd_req_q, mem_rd_req_d;
    logic [NUM_PORTS-1:0] port_req;
    logic                 pick_valid;
    logic                 pick_port;
    logic                 wr_active;
    logic                 rd_active;
    logic [NUM_PORTS-1:0] wr_sel;
    logic [NUM_PORTS-1:0] rd_sel;

    assign port_req = i_wr_burst_req | i_rd_burst_req;

`ifdef SDRAM_ARB_RR_EN
    logic last_q, last_d;
`endif

    sdram_arb_pick u_pick (
`ifdef SDRAM_ARB_RR_EN
        .last   (last_q),
`endif
        .req    (port_req),
        .valid  (pick_valid),
        .winner (pick_port)
    );

    // Next-state and next-grant; upstream fields are only sampled in IDLE.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        mem_wr_req_d = mem_wr_req_q;
        mem_rd_req_d = mem_rd_req_q;
`ifdef SDRAM_ARB_RR_EN
        last_d       = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d.port = pick_port;
                    if (i_wr_burst_req[pick_port]) begin
                        grant_d.kind = KIND_WR;
                        grant_d.len  = GRANT_LEN_W'(pick_port ? i_wr_burst_len[2*BW-1 -: BW]
                                                              : i_wr_burst_len[BW-1:0]);
                        grant_d.addr = GRANT_ADDR_W'(pick_port ? i_wr_burst_addr[2*AW-1 -: AW]
                                                               : i_wr_burst_addr[AW-1:0]);
                        mem_wr_req_d = 1'b1;
                        state_d      = ST_WR_GRANT;
                    end else begin
                        grant_d.kind = KIND_RD;
                        grant_d.len  = GRANT_LEN_W'(pick_port ? i_rd_burst_len[2*BW-1 -: BW]
                                                              : i_rd_burst_len[BW-1:0]);
                        grant_d.addr = GRANT_ADDR_W'(pick_port ? i_rd_burst_addr[2*AW-1 -: AW]
                                                               : i_rd_burst_addr[AW-1:0]);
                        mem_rd_req_d = 1'b1;
                        state_d      = ST_RD_GRANT;
                    end
                end
            end
            ST_WR_GRANT: begin
                if (i_mem_wr_burst_finish) begin
                    mem_wr_req_d = 1'b0;
                    state_d      = ST_RELEASE;
`ifdef SDRAM_ARB_RR_EN
                    last_d       = grant_q.port;
`endif
                end
            end
            ST_RD_GRANT: begin
                if (i_mem_rd_burst_finish) begin
                    mem_rd_req_d = 1'b0;
                    state_d      = ST_RELEASE;
`ifdef SDRAM_ARB_RR_EN
                    last_d       = grant_q.port;
`endif
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            mem_wr_req_q <= 1'b0;
            mem_rd_req_q <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_rd_req_q <= mem_rd_req_d;
`ifdef SDRAM_ARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

    assign o_mem_wr_burst_req  = mem_wr_req_q;
    assign o_mem_wr_burst_len  = BW'(grant_q.len);
    assign o_mem_wr_burst_addr = AW'(grant_q.addr);
    assign o_mem_rd_burst_req  = mem_rd_req_q;
    assign o_mem_rd_burst_len  = BW'(grant_q.len);
    assign o_mem_rd_burst_addr = AW'(grant_q.addr);

    // Zero-latency data/handshake routing, gated to the granted port and kind.
    assign wr_active = (state_q == ST_WR_GRANT) && (grant_q.kind == KIND_WR);
    assign rd_active = (state_q == ST_RD_GRANT) && (grant_q.kind == KIND_RD);
    assign wr_sel    = {wr_active & grant_q.port, wr_active & ~grant_q.port};
    assign rd_sel    = {rd_active & grant_q.port, rd_active & ~grant_q.port};

    assign o_wr_burst_data_req   = wr_sel & {NUM_PORTS{i_mem_wr_burst_data_req}};
    assign o_wr_burst_finish     = wr_sel & {NUM_PORTS{i_mem_wr_burst_finish}};
    assign o_rd_burst_data_valid = rd_sel & {NUM_PORTS{i_mem_rd_burst_data_valid}};
    assign o_rd_burst_finish     = rd_sel & {NUM_PORTS{i_mem_rd_burst_finish}};
    assign o_rd_burst_data       = rd_active ? i_mem_rd_burst_data : '0;
    assign o_mem_wr_burst_data   = !wr_active    ? '0 :
                                   grant_q.port ? i_wr_burst_data[2*DW-1 -: DW]
                                                : i_wr_burst_data[DW-1:0];

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench for sdram_burst_arbiter; arbitration expectations follow SDRAM_ARB_RR_EN.
module tb_sdram_burst_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        wr_req, rd_req;
    logic [2*BW-1:0]   wr_len, rd_len;
    logic [2*AW-1:0]   wr_addr, rd_addr;
    logic [2*DW-1:0]   wr_data;
    logic [1:0]        wr_data_req, wr_fin, rd_valid, rd_fin;
    logic [DW-1:0]     rd_data;
    logic              mem_wr_req, mem_rd_req;
    logic [BW-1:0]     mem_wr_len, mem_rd_len;
    logic [AW-1:0]     mem_wr_addr, mem_rd_addr;
    logic [DW-1:0]     mem_wr_data;
    logic              mem_wr_data_req, mem_wr_fin, mem_rd_valid, mem_rd_fin;
    logic [DW-1:0]     mem_rd_data;

    int n_cmp = 0;
    int n_err = 0;
    int m_last = 1;

    always #5 clk = ~clk;

    sdram_burst_arbiter dut (
        .i_sys_clk                 (clk),
        .i_sys_rst                 (rst),
        .i_wr_burst_req            (wr_req),
        .i_wr_burst_len            (wr_len),
        .i_wr_burst_addr           (wr_addr),
        .o_wr_burst_data_req       (wr_data_req),
        .i_wr_burst_data           (wr_data),
        .o_wr_burst_finish         (wr_fin),
        .i_rd_burst_req            (rd_req),
        .i_rd_burst_len            (rd_len),
        .i_rd_burst_addr           (rd_addr),
        .o_rd_burst_data_valid     (rd_valid),
        .o_rd_burst_data           (rd_data),
        .o_rd_burst_finish         (rd_fin),
        .o_mem_wr_burst_req        (mem_wr_req),
        .o_mem_wr_burst_len        (mem_wr_len),
        .o_mem_wr_burst_addr       (mem_wr_addr),
        .i_mem_wr_burst_data_req   (mem_wr_data_req),
        .o_mem_wr_burst_data       (mem_wr_data),
        .i_mem_wr_burst_finish     (mem_wr_fin),
        .o_mem_rd_burst_req        (mem_rd_req),
        .o_mem_rd_burst_len        (mem_rd_len),
        .o_mem_rd_burst_addr       (mem_rd_addr),
        .i_mem_rd_burst_data_valid (mem_rd_valid),
        .i_mem_rd_burst_data       (mem_rd_data),
        .i_mem_rd_burst_finish     (mem_rd_fin)
    );

    // Reference arbitration rule: which port wins for a given request pattern.
    function automatic int model_pick(input logic [1:0] req, input int last);
`ifdef SDRAM_ARB_RR_EN
        if (req == 2'b11) return 1 - last;
`else
        if (req == 2'b11) return 0 + (last & 0);
`endif
        return req[1] ? 1 : 0;
    endfunction

    task automatic set_wr(input int p, input logic [BW-1:0] len, input logic [AW-1:0] addr);
        wr_len[p*BW +: BW]  = len;
        wr_addr[p*AW +: AW] = addr;
    endtask

    task automatic set_rd(input int p, input logic [BW-1:0] len, input logic [AW-1:0] addr);
        rd_len[p*BW +: BW]  = len;
        rd_addr[p*AW +: AW] = addr;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        wr_req = '0; rd_req = '0; wr_len = '0; rd_len = '0; wr_addr = '0; rd_addr = '0;
        wr_data = '0; mem_wr_data_req = 1'b0; mem_wr_fin = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_data = '0; mem_rd_fin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_last = 1;
        #1;
    endtask

    // Plays the SDRAM controller for one burst; returns what it saw plus a count of routing errors.
    task automatic serve_burst(input int exp_port, output int waited, output logic got_wr,
                               output logic got_rd, output logic [BW-1:0] len_o,
                               output logic [AW-1:0] addr_o, output int bad,
                               output logic [3:0] fin_o, output logic req_low);
        waited = 0; bad = 0; got_wr = 0; got_rd = 0; len_o = '0; addr_o = '0;
        fin_o = '0; req_low = 0;
        while (!(mem_wr_req || mem_rd_req) && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!(mem_wr_req || mem_rd_req)) return;
        got_wr = mem_wr_req;
        got_rd = mem_rd_req;
        len_o  = got_wr ? mem_wr_len  : mem_rd_len;
        addr_o = got_wr ? mem_wr_addr : mem_rd_addr;
        // Finish of the other kind must be ignored.
        @(negedge clk);
        if (got_wr) mem_rd_fin = 1'b1; else mem_wr_fin = 1'b1;
        #1;
        if ({rd_fin, wr_fin} !== 4'b0) bad++;
        @(negedge clk);
        mem_rd_fin = 1'b0; mem_wr_fin = 1'b0;
        #1;
        if ((got_wr ? mem_wr_req : mem_rd_req) !== 1'b1) bad++;
        for (int i = 0; i < int'(len_o); i++) begin
            @(negedge clk);
            if (got_wr) begin
                mem_wr_data_req = 1'b1;
                wr_data = 32'($urandom);
            end else begin
                mem_rd_valid = 1'b1;
                mem_rd_data = 16'($urandom);
            end
            #1;
            if (got_wr) begin
                if (wr_data_req !== 2'(1 << exp_port)) bad++;
                if (mem_wr_data !== wr_data[exp_port*DW +: DW]) bad++;
                if (rd_valid !== 2'b00) bad++;
                if (mem_wr_addr !== addr_o || mem_wr_len !== len_o) bad++;
            end else begin
                if (rd_valid !== 2'(1 << exp_port)) bad++;
                if (rd_data !== mem_rd_data) bad++;
                if (wr_data_req !== 2'b00) bad++;
                if (mem_rd_addr !== addr_o || mem_rd_len !== len_o) bad++;
            end
        end
        @(negedge clk);
        mem_wr_data_req = 1'b0; mem_rd_valid = 1'b0;
        if (got_wr) mem_wr_fin = 1'b1; else mem_rd_fin = 1'b1;
        #1;
        fin_o = {rd_fin, wr_fin};
        @(negedge clk);
        mem_wr_fin = 1'b0; mem_rd_fin = 1'b0;
        #1;
        req_low = !(mem_wr_req || mem_rd_req);
        if ({rd_fin, wr_fin} !== 4'b0) bad++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({mem_wr_req, mem_rd_req} !== 2'b00) begin
            n_err++; $display("FAIL reset_req: got %b expected 00", {mem_wr_req, mem_rd_req});
        end
        n_cmp++;
        if ({mem_wr_len, mem_wr_addr, mem_rd_len, mem_rd_addr} !== '0) begin
            n_err++; $display("FAIL reset_len_addr: got %0h expected 0",
                              {mem_wr_len, mem_wr_addr, mem_rd_len, mem_rd_addr});
        end
        n_cmp++;
        if ({wr_data_req, wr_fin, rd_valid, rd_fin, rd_data, mem_wr_data} !== '0) begin
            n_err++; $display("FAIL reset_route: got %0h expected 0",
                              {wr_data_req, wr_fin, rd_valid, rd_fin, rd_data, mem_wr_data});
        end
    endtask

    task automatic test_single_write();
        int w, bad; logic gw, gr, rl; logic [BW-1:0] l; logic [AW-1:0] a; logic [3:0] f;
        @(negedge clk);
        set_wr(0, 6'd63, 24'h000000);
        wr_req = 2'b01;
        #1;
        serve_burst(0, w, gw, gr, l, a, bad, f, rl);
        wr_req = 2'b00;
        m_last = 0;
        n_cmp++;
        if (w !== 1) begin n_err++; $display("FAIL sw_latency: got %0d expected 1", w); end
        n_cmp++;
        if ({gw, gr} !== 2'b10) begin n_err++; $display("FAIL sw_kind: got %b expected 10", {gw, gr}); end
        n_cmp++;
        if (l !== 6'd63 || a !== 24'h0) begin
            n_err++; $display("FAIL sw_len_addr: got %0d/%0h expected 63/0", l, a);
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL sw_datapath: got %0d errors expected 0", bad); end
        n_cmp++;
        if (f !== 4'b0001) begin n_err++; $display("FAIL sw_finish: got %b expected 0001", f); end
        n_cmp++;
        if (rl !== 1'b1) begin n_err++; $display("FAIL sw_req_clear: got %b expected 1", rl); end
    endtask

    task automatic test_mixed_ports();
        int w, bad, exp; logic gw, gr, rl; logic [BW-1:0] l, l0, l1; logic [AW-1:0] a, a0, a1;
        logic [3:0] f;
        apply_reset();
        l0 = 6'($urandom_range(1, 12)); a0 = 24'($urandom);
        l1 = 6'($urandom_range(1, 12)); a1 = 24'($urandom);
        @(negedge clk);
        set_wr(0, l0, a0); set_rd(1, l1, a1);
        wr_req = 2'b01; rd_req = 2'b10;
        #1;
        exp = model_pick(2'b11, m_last);
        serve_burst(exp, w, gw, gr, l, a, bad, f, rl);
        wr_req = 2'b00;
        m_last = exp;
        n_cmp++;
        if ({gw, gr, l, a, f} !== {2'b10, l0, a0, 4'b0001} || bad !== 0) begin
            n_err++; $display("FAIL mix_first: got %b%b len %0d addr %0h fin %b bad %0d expected wr len %0d addr %0h fin 0001",
                              gw, gr, l, a, f, bad, l0, a0);
        end
        exp = model_pick(2'b10, m_last);
        serve_burst(exp, w, gw, gr, l, a, bad, f, rl);
        rd_req = 2'b00;
        m_last = exp;
        n_cmp++;
        if (w !== 2) begin n_err++; $display("FAIL mix_gap: got %0d expected 2", w); end
        n_cmp++;
        if ({gw, gr, l, a, f} !== {2'b01, l1, a1, 4'b1000} || bad !== 0) begin
            n_err++; $display("FAIL mix_second: got %b%b len %0d addr %0h fin %b bad %0d expected rd len %0d addr %0h fin 1000",
                              gw, gr, l, a, f, bad, l1, a1);
        end
    endtask

    task automatic test_alternate();
        int w, bad, exp; logic gw, gr, rl; logic [BW-1:0] l; logic [AW-1:0] a; logic [3:0] f;
        logic [BW-1:0] pl [2]; logic [AW-1:0] pa [2];
        repeat (3) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            pl[p] = 6'($urandom_range(1, 8));
            pa[p] = {1'(p), 23'($urandom)};
            set_wr(p, pl[p], pa[p]);
        end
        wr_req = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = model_pick(2'b11, m_last);
            serve_burst(exp, w, gw, gr, l, a, bad, f, rl);
            m_last = exp;
            n_cmp++;
            if (a !== pa[exp] || l !== pl[exp] || gw !== 1'b1) begin
                n_err++; $display("FAIL alt_grant%0d: got addr %0h len %0d expected port %0d addr %0h len %0d",
                                  k, a, l, exp, pa[exp], pl[exp]);
            end
            n_cmp++;
            if (w !== ((k == 0) ? 1 : 2) || bad !== 0 || f !== 4'(1 << exp)) begin
                n_err++; $display("FAIL alt_timing%0d: got wait %0d bad %0d fin %b expected wait %0d bad 0 fin %b",
                                  k, w, bad, f, (k == 0) ? 1 : 2, 4'(1 << exp));
            end
        end
        wr_req = 2'b00;
    endtask

    task automatic test_wr_before_rd();
        int w, bad; logic gw, gr, rl; logic [BW-1:0] l, lw, lr; logic [AW-1:0] a, aw, ar;
        logic [3:0] f;
        repeat (3) @(negedge clk);
        lw = 6'($urandom_range(1, 10)); aw = 24'($urandom);
        lr = 6'($urandom_range(1, 10)); ar = 24'($urandom);
        set_wr(0, lw, aw); set_rd(0, lr, ar);
        wr_req = 2'b01; rd_req = 2'b01;
        #1;
        serve_burst(0, w, gw, gr, l, a, bad, f, rl);
        wr_req = 2'b00;
        n_cmp++;
        if ({gw, gr, l, a, f} !== {2'b10, lw, aw, 4'b0001} || bad !== 0) begin
            n_err++; $display("FAIL wrrd_first: got %b%b len %0d addr %0h fin %b expected write len %0d addr %0h",
                              gw, gr, l, a, f, lw, aw);
        end
        serve_burst(0, w, gw, gr, l, a, bad, f, rl);
        rd_req = 2'b00;
        m_last = 0;
        n_cmp++;
        if ({gw, gr, l, a, f} !== {2'b01, lr, ar, 4'b0100} || bad !== 0 || w !== 2) begin
            n_err++; $display("FAIL wrrd_second: got %b%b len %0d addr %0h fin %b wait %0d expected read len %0d addr %0h",
                              gw, gr, l, a, f, w, lr, ar);
        end
    endtask

    task automatic test_addr_hold();
        int w, bad; logic gw, gr, rl; logic [BW-1:0] l; logic [AW-1:0] a; logic [3:0] f;
        repeat (3) @(negedge clk);
        set_wr(0, 6'd9, 24'h000080);
        wr_req = 2'b01;
        @(negedge clk);
        // Upstream changes and drops its request after the grant has been taken.
        set_wr(0, 6'd3, 24'h000100);
        wr_req = 2'b00;
        #1;
        serve_burst(0, w, gw, gr, l, a, bad, f, rl);
        m_last = 0;
        n_cmp++;
        if (a !== 24'h000080 || l !== 6'd9) begin
            n_err++; $display("FAIL hold_addr: got addr %0h len %0d expected 80/9", a, l);
        end
        n_cmp++;
        if (bad !== 0 || f !== 4'b0001 || rl !== 1'b1) begin
            n_err++; $display("FAIL hold_burst: got bad %0d fin %b reqlow %b expected 0/0001/1", bad, f, rl);
        end
    endtask

    task automatic test_reset_mid_read();
        int w, cnt, leaks;
        repeat (3) @(negedge clk);
        set_rd(0, 6'd63, 24'($urandom));
        rd_req = 2'b01;
        w = 0;
        while (!mem_rd_req && w < 20) begin @(negedge clk); #1; w++; end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mem_rd_valid = 1'b1; mem_rd_data = 16'($urandom);
            #1;
            if (rd_valid === 2'b01 && rd_data === mem_rd_data) cnt++;
        end
        n_cmp++;
        if (cnt !== 40) begin n_err++; $display("FAIL rst_pre_valids: got %0d expected 40", cnt); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({wr_data_req, wr_fin, rd_valid, rd_data, rd_fin, mem_wr_req, mem_wr_len, mem_wr_addr,
             mem_wr_data, mem_rd_req, mem_rd_len, mem_rd_addr} !== '0) begin
            n_err++; $display("FAIL rst_outputs: got %0h expected 0",
                              {wr_data_req, wr_fin, rd_valid, rd_data, rd_fin, mem_wr_req, mem_wr_len,
                               mem_wr_addr, mem_wr_data, mem_rd_req, mem_rd_len, mem_rd_addr});
        end
        rd_req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        leaks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_rd_fin = (i == 3);
            #1;
            if (rd_valid !== 2'b00 || rd_fin !== 2'b00 || mem_rd_req !== 1'b0) leaks++;
        end
        mem_rd_valid = 1'b0; mem_rd_fin = 1'b0;
        n_cmp++;
        if (leaks !== 0) begin n_err++; $display("FAIL rst_no_leak: got %0d leaking cycles expected 0", leaks); end
    endtask

    initial begin
        rst = 1'b1;
        wr_req = '0; rd_req = '0; wr_len = '0; rd_len = '0; wr_addr = '0; rd_addr = '0;
        wr_data = '0; mem_wr_data_req = 1'b0; mem_wr_fin = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_data = '0; mem_rd_fin = 1'b0;
        test_reset();
        test_single_write();
        test_mixed_ports();
        test_alternate();
        test_wr_before_rd();
        test_addr_hold();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
